// File: rtl/cpu_types_pkg.sv
// rtl/cpu_types_pkg.sv - shared pipeline sequencer types and latch control constants
package cpu_types_pkg;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DWAIT  = 2'd1,
    HALTED = 2'd2
  } hazard_state_t;

  typedef struct packed {
    logic en;
    logic freeze;
    logic flush;
  } latch_ctrl_t;

  // Latch advances normally
  localparam latch_ctrl_t LC_ADVANCE = '{en: 1'b1, freeze: 1'b0, flush: 1'b0};
  // Latch holds its contents
  localparam latch_ctrl_t LC_FREEZE  = '{en: 1'b0, freeze: 1'b1, flush: 1'b0};
  // Latch loads a bubble
  localparam latch_ctrl_t LC_FLUSH   = '{en: 1'b1, freeze: 1'b0, flush: 1'b1};

endpackage

// File: rtl/hazard_detect.sv
// rtl/hazard_detect.sv - combinational load-use hazard compare between EX and ID
module hazard_detect #(
  parameter int REG_W = 5
) (
  input  logic             ex_memread,
  input  logic [REG_W-1:0] ex_rd,
  input  logic [REG_W-1:0] id_rs1,
  input  logic [REG_W-1:0] id_rs2,
  output logic             load_use
);

  // x0 is hardwired zero, so a load targeting it never creates a dependency
  always_comb begin
    load_use = ex_memread && (ex_rd != '0) &&
               ((ex_rd == id_rs1) || (ex_rd == id_rs2));
  end

endmodule

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - pipeline sequencer: stalls, flushes, redirects, halt (optional HAZARD_PERF_CNT_EN counters)
module hazard_ctrl #(
  parameter int REG_W = 5
`ifdef HAZARD_PERF_CNT_EN
  , parameter int CNT_W = 32
`endif
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             ihit,
  input  logic             dhit,
  input  logic             mem_dren,
  input  logic             mem_dwen,
  input  logic             ex_memread,
  input  logic [REG_W-1:0] ex_rd,
  input  logic [REG_W-1:0] id_rs1,
  input  logic [REG_W-1:0] id_rs2,
  input  logic             ex_redirect,
  input  logic             wb_halt,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             ifid_freeze,
  output logic             ifid_flush,
  output logic             idex_en,
  output logic             idex_freeze,
  output logic             idex_flush,
  output logic             exmem_en,
  output logic             exmem_freeze,
  output logic             exmem_flush,
  output logic             memwb_en,
  output logic             memwb_freeze,
  output logic             memwb_flush,
`ifdef HAZARD_PERF_CNT_EN
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
`endif
  output logic             halt
);

  import cpu_types_pkg::*;

  hazard_state_t state;
  latch_ctrl_t   ifid_c, idex_c, exmem_c, memwb_c;
  logic          load_use;
  logic          dstall;

  hazard_detect #(.REG_W(REG_W)) u_detect (
    .ex_memread (ex_memread),
    .ex_rd      (ex_rd),
    .id_rs1     (id_rs1),
    .id_rs2     (id_rs2),
    .load_use   (load_use)
  );

  // Resolve latch controls by priority: halted > dmem stall > redirect > load-use > fetch miss
  always_comb begin
    pc_en   = ihit;
    ifid_c  = ihit ? LC_ADVANCE : LC_FLUSH;
    idex_c  = LC_ADVANCE;
    exmem_c = LC_ADVANCE;
    memwb_c = LC_ADVANCE;
    dstall  = 1'b0;
    case (state)
      HALTED: begin
        pc_en   = 1'b0;
        ifid_c  = LC_FREEZE;
        idex_c  = LC_FREEZE;
        exmem_c = LC_FREEZE;
        memwb_c = LC_FREEZE;
      end
      default: begin
        // Once waiting, only dhit releases the stall; EX/MEM contents are frozen meanwhile
        dstall = (state == DWAIT) ? !dhit : ((mem_dren || mem_dwen) && !dhit);
        if (dstall) begin
          pc_en   = 1'b0;
          ifid_c  = LC_FREEZE;
          idex_c  = LC_FREEZE;
          exmem_c = LC_FREEZE;
          memwb_c = LC_FLUSH;
        end else if (ex_redirect) begin
          // Younger instructions are squashed, so any load-use match is moot
          pc_en  = 1'b1;
          ifid_c = LC_FLUSH;
          idex_c = LC_FLUSH;
        end else if (load_use) begin
          pc_en  = 1'b0;
          ifid_c = LC_FREEZE;
          idex_c = LC_FLUSH;
        end
      end
    endcase
  end

  assign {ifid_en,  ifid_freeze,  ifid_flush}  = ifid_c;
  assign {idex_en,  idex_freeze,  idex_flush}  = idex_c;
  assign {exmem_en, exmem_freeze, exmem_flush} = exmem_c;
  assign {memwb_en, memwb_freeze, memwb_flush} = memwb_c;

  // Sequencer state and sticky halt flag; HALTED is left only through RST
  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= RUN;
      halt  <= 1'b0;
    end else begin
      case (state)
        HALTED: state <= HALTED;
        default: begin
          if (wb_halt && !(state == DWAIT && dstall)) begin
            state <= HALTED;
            halt  <= 1'b1;
          end else if (dstall) begin
            state <= DWAIT;
          end else begin
            state <= RUN;
          end
        end
      endcase
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  // Free-running wrap-around counters of lost fetch cycles and ID/EX bubbles while live
  always_ff @(posedge CLK) begin
    if (RST) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else if (state != HALTED) begin
      if (!pc_en)     stall_cnt <= stall_cnt + CNT_W'(1);
      if (idex_flush) flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - directed self-checking bench for hazard_ctrl
module tb_hazard_ctrl;

  logic       CLK = 1'b0;
  logic       RST;
  logic       ihit, dhit, mem_dren, mem_dwen, ex_memread, ex_redirect, wb_halt;
  logic [4:0] ex_rd, id_rs1, id_rs2;
  logic       pc_en, halt;
  logic       ifid_en, ifid_freeze, ifid_flush;
  logic       idex_en, idex_freeze, idex_flush;
  logic       exmem_en, exmem_freeze, exmem_flush;
  logic       memwb_en, memwb_freeze, memwb_flush;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cnt, flush_cnt;
`endif

  int errors = 0;
  int checks = 0;

  // {pc_en, ifid en/fr/fl, idex en/fr/fl, exmem en/fr/fl, memwb en/fr/fl, halt}
  localparam logic [13:0] V_ADV   = 14'b1_100_100_100_100_0;
  localparam logic [13:0] V_MISS  = 14'b0_101_100_100_100_0;
  localparam logic [13:0] V_DSTL  = 14'b0_010_010_010_101_0;
  localparam logic [13:0] V_LDUSE = 14'b0_010_101_100_100_0;
  localparam logic [13:0] V_REDIR = 14'b1_101_101_100_100_0;
  localparam logic [13:0] V_HALT  = 14'b0_010_010_010_010_1;

  hazard_ctrl dut (
    .CLK          (CLK),
    .RST          (RST),
    .ihit         (ihit),
    .dhit         (dhit),
    .mem_dren     (mem_dren),
    .mem_dwen     (mem_dwen),
    .ex_memread   (ex_memread),
    .ex_rd        (ex_rd),
    .id_rs1       (id_rs1),
    .id_rs2       (id_rs2),
    .ex_redirect  (ex_redirect),
    .wb_halt      (wb_halt),
    .pc_en        (pc_en),
    .ifid_en      (ifid_en),
    .ifid_freeze  (ifid_freeze),
    .ifid_flush   (ifid_flush),
    .idex_en      (idex_en),
    .idex_freeze  (idex_freeze),
    .idex_flush   (idex_flush),
    .exmem_en     (exmem_en),
    .exmem_freeze (exmem_freeze),
    .exmem_flush  (exmem_flush),
    .memwb_en     (memwb_en),
    .memwb_freeze (memwb_freeze),
    .memwb_flush  (memwb_flush),
`ifdef HAZARD_PERF_CNT_EN
    .stall_cnt    (stall_cnt),
    .flush_cnt    (flush_cnt),
`endif
    .halt         (halt)
  );

  always #5 CLK = ~CLK;

  function automatic logic [13:0] observed();
    return {pc_en, ifid_en, ifid_freeze, ifid_flush, idex_en, idex_freeze, idex_flush,
            exmem_en, exmem_freeze, exmem_flush, memwb_en, memwb_freeze, memwb_flush, halt};
  endfunction

  // Inputs were applied just after a falling edge; compare 1ns later, then move to the next falling edge
  task automatic step(input logic [13:0] exp, input string tag);
    logic [13:0] obs;
    #1;
    obs = observed();
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
    @(negedge CLK);
  endtask

  task automatic idle_inputs();
    ihit = 1'b1; dhit = 1'b0; mem_dren = 1'b0; mem_dwen = 1'b0;
    ex_memread = 1'b0; ex_redirect = 1'b0; wb_halt = 1'b0;
    ex_rd = 5'd0; id_rs1 = 5'd0; id_rs2 = 5'd0;
  endtask

`ifdef HAZARD_PERF_CNT_EN
  task automatic check_cnt(input logic [31:0] exp_s, input logic [31:0] exp_f, input string tag);
    checks++;
    assert (stall_cnt === exp_s) else begin
      errors++;
      $error("FAIL %s_stall: observed=%0d expected=%0d", tag, stall_cnt, exp_s);
    end
    checks++;
    assert (flush_cnt === exp_f) else begin
      errors++;
      $error("FAIL %s_flush: observed=%0d expected=%0d", tag, flush_cnt, exp_f);
    end
  endtask
`endif

  initial begin
    RST = 1'b1;
    idle_inputs();
    @(negedge CLK);
    step(V_ADV, "reset_run");
    RST = 1'b0;
    step(V_ADV, "idle_advance");
`ifdef HAZARD_PERF_CNT_EN
    check_cnt(32'd0, 32'd0, "cnt_reset");
`endif
    ihit = 1'b0;
    step(V_MISS, "ihit_miss_bubble");
    ihit = 1'b1;

    mem_dren = 1'b1; dhit = 1'b1;
    step(V_ADV, "dmem_first_cycle_hit");
    dhit = 1'b0;
    step(V_DSTL, "dwait_cycle1");
    step(V_DSTL, "dwait_cycle2");
    step(V_DSTL, "dwait_cycle3");
    dhit = 1'b1;
    step(V_ADV, "dwait_dhit_advance");
    mem_dren = 1'b0; dhit = 1'b0;
    step(V_ADV, "dwait_back_to_run");
    mem_dwen = 1'b1;
    step(V_DSTL, "store_stall");
    dhit = 1'b1;
    step(V_ADV, "store_done");
    mem_dwen = 1'b0; dhit = 1'b0;

    ex_memread = 1'b1; ex_rd = 5'd5; id_rs2 = 5'd5;
    step(V_LDUSE, "load_use_rs2");
    ex_memread = 1'b0; ex_rd = 5'd0; id_rs2 = 5'd0;
    step(V_ADV, "load_use_one_bubble");
    ex_memread = 1'b1;
    step(V_ADV, "load_use_x0_ignored");
    ex_rd = 5'd7; id_rs1 = 5'd7; id_rs2 = 5'd3;
    step(V_LDUSE, "load_use_rs1");
    ex_rd = 5'd8;
    step(V_ADV, "load_no_match");

    ex_rd = 5'd3; ex_redirect = 1'b1;
    step(V_REDIR, "redirect_beats_load_use");
    idle_inputs();

    mem_dren = 1'b1; ex_redirect = 1'b1;
    step(V_DSTL, "redirect_in_dwait1");
    step(V_DSTL, "redirect_in_dwait2");
    dhit = 1'b1;
    step(V_REDIR, "redirect_on_dhit");
    idle_inputs();
    step(V_ADV, "after_redirect");

    wb_halt = 1'b1;
    step(V_ADV, "halt_request_cycle");
    wb_halt = 1'b0; mem_dren = 1'b1; ex_redirect = 1'b1; ihit = 1'b0;
    for (int i = 0; i < 10; i++) step(V_HALT, $sformatf("halted_%0d", i));
`ifdef HAZARD_PERF_CNT_EN
    check_cnt(32'd9, 32'd4, "cnt_totals");
`endif

    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    idle_inputs();
    step(V_ADV, "reset_from_halt");
`ifdef HAZARD_PERF_CNT_EN
    check_cnt(32'd0, 32'd0, "cnt_after_reset");
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
